// File: rtl/flex_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flex_shift_pkg
// Description : Shared types and helpers for the flexible shift register.
//               shift_mode_t : operation select (HOLD/SHIFT/LOAD/CLEAR)
//               cnt_width()  : bit-counter width for a given register width
// Revision    : 1.0 - initial release
// ============================================================================
package flex_shift_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        SHIFT = 2'b01,
        LOAD  = 2'b10,
        CLEAR = 2'b11
    } shift_mode_t;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : flex_shift_pkg
`default_nettype wire

// File: rtl/shift_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : shift_bit_counter
// Description : Modulo-WIDTH shift counter with a wrap indication.
//   clk   in   rising-edge clock
//   nrst  in   asynchronous active-low reset
//   inc   in   count one shift
//   clr   in   restart the frame (priority over inc)
//   count out  registered shifts completed in the current frame
//   wrap  out  combinational: this inc completes the frame
// Revision    : 1.0 - initial release
// ============================================================================
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;

    // Wrap is only meaningful when a shift actually happens this cycle.
    assign wrap  = inc && !clr && (r_count == c_MAX);
    assign count = r_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule : shift_bit_counter
`default_nettype wire

// File: rtl/flex_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : flex_shift_reg
// Description : Parametrised bidirectional shift register with framed bit
//               counter, for serial peripherals (DAC, config chain).
//   clk          in   rising-edge clock
//   nrst         in   asynchronous active-low reset
//   mode_i       in   00 HOLD, 01 SHIFT, 10 LOAD, 11 CLEAR
//   D            in   serial input bit (SHIFT)
//   par_i        in   parallel load word (LOAD)
//   Q            out  registered contents
//   serial_o     out  next bit to leave (combinational from Q)
//   bit_cnt_o    out  registered shifts completed in the current frame
//   frame_done_o out  one-cycle registered pulse after the last frame shift
// Revision    : 1.0 - initial release
// ============================================================================
module flex_shift_reg
    import flex_shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter bit               MSB_FIRST   = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [1:0]                    mode_i,
    input  logic                          D,
    input  logic [WIDTH-1:0]              par_i,
    output logic [WIDTH-1:0]              Q,
    output logic                          serial_o,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt_o,
    output logic                          frame_done_o
);

    localparam int c_CNT_W = cnt_width(WIDTH);

    shift_mode_t      w_mode;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_inc;
    logic             w_clr;
    logic             w_wrap;
    logic             r_frame_done;

    assign w_mode = shift_mode_t'(mode_i);

    // Shift direction is fixed at elaboration; only one path exists in hardware.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_q[WIDTH-2:0], D};
            assign serial_o  = r_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {D, r_q[WIDTH-1:1]};
            assign serial_o  = r_q[0];
        end
    endgenerate

    always_comb begin
        w_q_next = r_q;
        w_inc    = 1'b0;
        w_clr    = 1'b0;
        case (w_mode)
            SHIFT: begin
                w_q_next = w_shifted;
                w_inc    = 1'b1;
            end
            LOAD: begin
                w_q_next = par_i;
                w_clr    = 1'b1;
            end
            CLEAR: begin
                w_q_next = RESET_VALUE;
                w_clr    = 1'b1;
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (c_CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (w_inc),
        .clr   (w_clr),
        .count (bit_cnt_o),
        .wrap  (w_wrap)
    );

    // Registering the wrap gives the pulse in the cycle after the last shift;
    // it drops automatically because wrap is only high on a wrapping shift.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q          <= RESET_VALUE;
            r_frame_done <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_frame_done <= w_wrap;
        end
    end

    assign Q            = r_q;
    assign frame_done_o = r_frame_done;

endmodule : flex_shift_reg
`default_nettype wire
